reg_bank_arbiter: RTL

Owns the 32 x 8 configuration register bank and shares it between several requesters: the I2C slave byte path, the IO sampler writing back input status, and future internal masters. Round-robin arbitration with an optional locked burst so a multi-byte I2C transfer to auto-incremented registers is not interleaved. The full bank is exported flat to the IO/PWM datapath every cycle.

---
 rtl/reg_arb_pkg.sv | 16 +
 rtl/reg_bank_arbiter_if.sv | 28 ++
 rtl/reg_bank_arbiter_rr_picker.sv | 30 +++
 rtl/reg_bank_arbiter.sv | 124 ++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: shared constants and FSM state type
// for the configuration register bank arbiter.
package reg_arb_pkg;

    localparam int REGCOUNT   = 32;
    localparam int DW         = 8;
    localparam int AW         = $clog2(REGCOUNT);
    localparam int HOLD_LIMIT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/reg_bank_arbiter_if.sv
// reg_bank_arbiter_if: requester-side bus of the register bank,
// one packed slice per requester.
interface reg_bank_arbiter_if
    import reg_arb_pkg::*;
#(
    parameter int NREQ = 2
) ();

    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    lock;
    logic [NREQ-1:0]    we;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    ack;
    logic [DW-1:0]      rdata;

    modport master (
        output req, lock, we, addr, wdata,
        input  gnt, ack, rdata
    );

    modport slave (
        input  req, lock, we, addr, wdata,
        output gnt, ack, rdata
    );

endinterface

// File: rtl/reg_bank_arbiter_rr_picker.sv
// rr_picker: combinational round-robin select, scanning
// from last+1 modulo NREQ.
module rr_picker #(
    parameter int NREQ = 2,
    parameter int LW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [LW-1:0]   last,
    output logic [NREQ-1:0] onehot,
    output logic [LW-1:0]   idx,
    output logic            valid
);

    always_comb begin
        int i;
        i      = 0;
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            i = (int'(last) + k) % NREQ;
            if (!valid && req[i]) begin
                valid     = 1'b1;
                onehot[i] = 1'b1;
                idx       = LW'(i);
            end
        end
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: 32x8 register bank shared round-robin with locked bursts.
// Define REG_ARB_HOLD_LIMIT_EN to force release after HOLD_LIMIT burst accesses.
module reg_bank_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    reg_bank_arbiter_if.slave      bus,
    output logic [REGCOUNT*DW-1:0] registers_packed
);

    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e      state;
    logic [LW-1:0]   last;
    logic [LW-1:0]   win;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] ack_q;
    logic [DW-1:0]   rdata_q;
    logic [DW-1:0]   bank [REGCOUNT];

    logic [NREQ-1:0] pick_oh;
    logic [LW-1:0]   pick_idx;
    logic            pick_valid;

    logic            win_req;
    logic            win_lock;
    logic            win_we;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_wdata;
    logic            at_limit;

    rr_picker #(
        .NREQ (NREQ),
        .LW   (LW)
    ) u_pick (
        .req    (bus.req),
        .last   (last),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    assign win_req   = bus.req[win];
    assign win_lock  = bus.lock[win];
    assign win_we    = bus.we[win];
    assign win_addr  = bus.addr[int'(win)*AW +: AW];
    assign win_wdata = bus.wdata[int'(win)*DW +: DW];

`ifdef REG_ARB_HOLD_LIMIT_EN
    localparam int CW = $clog2(HOLD_LIMIT) + 1;

    logic [CW-1:0] cnt;

    // cnt holds the number of accesses already done in this burst
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (state == GRANT) begin
            cnt <= CW'(1);
        end else if (state == HOLD && win_req) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign at_limit = (state == HOLD) && (cnt == CW'(HOLD_LIMIT - 1));
`else
    assign at_limit = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            last    <= LW'(NREQ - 1);
            win     <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            rdata_q <= '0;
            for (int k = 0; k < REGCOUNT; k++) begin
                bank[k] <= '0;
            end
        end else begin
            ack_q <= '0;
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt_q <= pick_oh;
                        win   <= pick_idx;
                        state <= GRANT;
                    end
                end
                GRANT, HOLD: begin
                    if (win_req) begin
                        ack_q <= gnt_q;
                        if (win_we) begin
                            bank[win_addr] <= win_wdata;
                        end else begin
                            rdata_q <= bank[win_addr];
                        end
                    end
                    if (win_req && win_lock && !at_limit) begin
                        state <= HOLD;
                    end else begin
                        state <= IDLE;
                        gnt_q <= '0;
                        last  <= win;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.ack   = ack_q;
    assign bus.rdata = rdata_q;

    for (genvar k = 0; k < REGCOUNT; k++) begin : g_flat
        assign registers_packed[k*DW +: DW] = bank[k];
    end

endmodule
